gc_dram_refresh_ctrl: RTL

Controller that sits directly upstream of the 128x64 gain-cell DRAM array and owns all of its ports (re/we/raddr/waddr/in/rd). It accepts host read and write requests through a valid/ready port. It also refreshes each row (read, then write back) before the array's 5000-cycle data-retention limit expires. Refresh is row round-robin, may be deferred briefly behind host traffic, and skips rows already renewed by a host write.

---
 rtl/gc_dram_refresh_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/gc_dram_refresh_ctrl.sv
// gc_dram_refresh_ctrl: host valid/ready port plus round-robin read/write-back refresh of a gain-cell DRAM array
module gc_dram_refresh_ctrl #(
  parameter int ROWS = 128,
  parameter int WIDTH = 64,
  parameter int REFRESH_INTERVAL = 16,
  parameter int MAX_DEFER = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_req_valid,
  output logic                     host_req_ready,
  input  logic                     host_we,
  input  logic [$clog2(ROWS)-1:0]  host_addr,
  input  logic [WIDTH-1:0]         host_wdata,
  output logic                     host_rsp_valid,
  output logic [WIDTH-1:0]         host_rsp_data,
  output logic                     dram_re,
  output logic                     dram_we,
  output logic [$clog2(ROWS)-1:0]  dram_raddr,
  output logic [$clog2(ROWS)-1:0]  dram_waddr,
  output logic [WIDTH-1:0]         dram_wdata,
  input  logic [WIDTH-1:0]         dram_rd,
  output logic                     refresh_overrun
);
  localparam int AW = $clog2(ROWS);
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int DW = $clog2(MAX_DEFER + 1);
  localparam logic [1:0] IDLE = 2'd0, REF_RD = 2'd1, REF_WB = 2'd2;
  logic [1:0] state;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [TW-1:0] tick_cnt;
  logic [DW-1:0] defer_cnt;
  logic [ROWS-1:0] written;
  logic ref_pending, rd_pend, wrap, accept, ref_done;
  assign wrap = tick_cnt == TW'(REFRESH_INTERVAL - 1);
  assign ptr_nxt = ptr == AW'(ROWS - 1) ? '0 : ptr + 1'b1;
  assign host_req_ready = state == IDLE && !(ref_pending && defer_cnt == DW'(MAX_DEFER));
  assign accept = host_req_valid && host_req_ready;
  // a row renewed by a host write is skipped instead of refreshed
  assign ref_done = (state == IDLE && !accept && ref_pending && written[ptr]) || state == REF_WB;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      tick_cnt <= '0;
      defer_cnt <= '0;
      written <= '0;
      ref_pending <= 1'b0;
      refresh_overrun <= 1'b0;
      rd_pend <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_data <= '0;
      dram_re <= 1'b0;
      dram_we <= 1'b0;
      dram_raddr <= '0;
      dram_waddr <= '0;
      dram_wdata <= '0;
    end else begin
      tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
      ref_pending <= wrap || (ref_pending && !ref_done);
      if (wrap && ref_pending && !ref_done) refresh_overrun <= 1'b1;
      dram_re <= 1'b0;
      dram_we <= 1'b0;
      rd_pend <= 1'b0;
      host_rsp_valid <= rd_pend;
      if (rd_pend) host_rsp_data <= dram_rd;
      if (ref_done) begin
        ptr <= ptr_nxt;
        defer_cnt <= '0;
        written[ptr] <= 1'b0;
      end
      if (state == IDLE) begin
        if (accept) begin
          if (ref_pending) defer_cnt <= defer_cnt + 1'b1;
          if (host_we) begin
            dram_we <= 1'b1;
            dram_waddr <= host_addr;
            dram_wdata <= host_wdata;
            written[host_addr] <= 1'b1;
          end else begin
            dram_re <= 1'b1;
            dram_raddr <= host_addr;
            rd_pend <= 1'b1;
          end
        end else if (ref_pending && !written[ptr]) begin
          state <= REF_RD;
          dram_re <= 1'b1;
          dram_raddr <= ptr;
        end
      end else if (state == REF_RD) begin
        state <= REF_WB;
        dram_we <= 1'b1;
        dram_waddr <= ptr;
        dram_wdata <= dram_rd;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
